// File: rtl/alu_issue_sched.sv
// Issue scheduler: picks up to three ready requesters per cycle and assigns them to three ALUs.
// Memory ops hold their ALU until mem_done. Define ALU_SCHED_RR_EN for round-robin priority; otherwise fixed priority.
module alu_issue_sched #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [4*NUM_REQ-1:0]       req_optype,
    input  logic [TAG_W*NUM_REQ-1:0]   req_tag,
    output logic [NUM_REQ-1:0]         req_grant,
    input  logic [2:0]                 mem_done,
    output logic [2:0]                 alu_number,
    output logic [11:0]                alu_optype,
    output logic [3*TAG_W-1:0]         alu_tag,
    output logic [2:0]                 alu_busy
);
    localparam int NUM_ALU = 3;

    logic [NUM_REQ-1:0]       eligible;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_ALU-1:0]       free_left;
    logic                     taken;
    int                       start;
    logic [NUM_ALU-1:0]       number_d, number_q;
    logic [NUM_ALU-1:0]       busy_d, busy_q;
    logic [4*NUM_ALU-1:0]     optype_d, optype_q;
    logic [TAG_W*NUM_ALU-1:0] tag_d, tag_q;

`ifdef ALU_SCHED_RR_EN
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    logic [PTR_W-1:0] rr_ptr_d, rr_ptr_q;
    int               last_idx;
`endif

    // Reset masks eligibility so no grant escapes while rst is high.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = !rst && req_valid[i] && (req_optype[4*i +: 4] != 4'd0)
                          && (req_optype[4*i +: 4] <= 4'd10);
        end
    end

    always_comb begin
        grant     = '0;
        number_d  = '0;
        optype_d  = optype_q;
        tag_d     = tag_q;
        busy_d    = busy_q;
        taken     = 1'b0;
        free_left = ~busy_q | mem_done;
`ifdef ALU_SCHED_RR_EN
        start     = int'(rr_ptr_q);
        last_idx  = 0;
        rr_ptr_d  = rr_ptr_q;
`else
        start     = 0;
`endif
        for (int a = 0; a < NUM_ALU; a++) begin
            if (mem_done[a]) busy_d[a] = 1'b0;
        end
        // Walk requesters in priority order; each winner takes the lowest free ALU.
        for (int j = 0; j < NUM_REQ; j++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == (start + j) % NUM_REQ && eligible[i] && free_left != '0) begin
                    grant[i] = 1'b1;
`ifdef ALU_SCHED_RR_EN
                    last_idx = i;
`endif
                    taken = 1'b0;
                    for (int a = 0; a < NUM_ALU; a++) begin
                        if (free_left[a] && !taken) begin
                            taken                    = 1'b1;
                            free_left[a]             = 1'b0;
                            number_d[a]              = 1'b1;
                            optype_d[4*a +: 4]       = req_optype[4*i +: 4];
                            tag_d[TAG_W*a +: TAG_W]  = req_tag[TAG_W*i +: TAG_W];
                            busy_d[a]                = (req_optype[4*i +: 4] >= 4'd7);
                        end
                    end
                end
            end
        end
`ifdef ALU_SCHED_RR_EN
        if (grant != '0) rr_ptr_d = PTR_W'((last_idx + 1) % NUM_REQ);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            number_q <= '0;
            busy_q   <= '0;
            optype_q <= '0;
            tag_q    <= '0;
`ifdef ALU_SCHED_RR_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            number_q <= number_d;
            busy_q   <= busy_d;
            optype_q <= optype_d;
            tag_q    <= tag_d;
`ifdef ALU_SCHED_RR_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign req_grant  = grant;
    assign alu_number = number_q;
    assign alu_busy   = busy_q;
    assign alu_optype = optype_q;
    assign alu_tag    = tag_q;
endmodule

// File: tb/tb_alu_issue_sched.sv
// Bench for alu_issue_sched: directed vector table, a hand-written busy/mem_done sequence,
// then random traffic against a queue-based scheduling model.
module tb_alu_issue_sched;
    localparam int N  = 4;
    localparam int TW = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [4*N-1:0] req_optype;
    logic [TW*N-1:0] req_tag;
    logic [N-1:0]   req_grant;
    logic [2:0]     mem_done;
    logic [2:0]     alu_number;
    logic [11:0]    alu_optype;
    logic [3*TW-1:0] alu_tag;
    logic [2:0]     alu_busy;

    always #5 clk = ~clk;

    alu_issue_sched #(.NUM_REQ(N), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_optype(req_optype),
        .req_tag(req_tag), .req_grant(req_grant), .mem_done(mem_done),
        .alu_number(alu_number), .alu_optype(alu_optype), .alu_tag(alu_tag),
        .alu_busy(alu_busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [15:0] opt;
        logic [23:0] tag;
        logic [2:0]  md;
        logic [3:0]  g;
        logic [2:0]  num;
        logic [2:0]  busy;
        logic        chk_tag;
        logic [17:0] atag;
    } vec_t;

    function automatic vec_t mk(logic r, logic [3:0] v, logic [15:0] o, logic [23:0] t,
                                logic [2:0] md, logic [3:0] g, logic [2:0] num,
                                logic [2:0] busy, logic ct, logic [17:0] at);
        vec_t x;
        x.rst = r; x.valid = v; x.opt = o; x.tag = t; x.md = md;
        x.g = g; x.num = num; x.busy = busy; x.chk_tag = ct; x.atag = at;
        return x;
    endfunction

    task automatic apply(input vec_t v, input string nm);
        rst = v.rst; req_valid = v.valid; req_optype = v.opt; req_tag = v.tag; mem_done = v.md;
        #1;
        chk({nm, "_grant"}, 32'(req_grant), 32'(v.g));
        @(posedge clk); #1;
        chk({nm, "_number"}, 32'(alu_number), 32'(v.num));
        chk({nm, "_busy"}, 32'(alu_busy), 32'(v.busy));
        if (v.chk_tag) chk({nm, "_tag"}, 32'(alu_tag), 32'(v.atag));
    endtask

    // Reference model state
    logic [2:0]  m_num, m_busy;
    logic [11:0] m_opt;
    logic [17:0] m_tag;
    int          m_rr;

    task automatic model_step(input logic r, input logic [3:0] v, input logic [15:0] o,
                              input logic [23:0] t, input logic [2:0] md, output logic [3:0] g);
        int freeq[$];
        int order[$];
        int n, st;
        g = '0;
        if (r) begin
            m_num = '0; m_busy = '0; m_opt = '0; m_tag = '0; m_rr = 0;
            return;
        end
        for (int k = 0; k < 3; k++)
            if (!m_busy[k] || md[k]) freeq.push_back(k);
`ifdef ALU_SCHED_RR_EN
        st = m_rr;
`else
        st = 0;
`endif
        for (int j = 0; j < N; j++) begin
            int i = (st + j) % N;
            int op = int'(o[4*i +: 4]);
            if (v[i] && op >= 1 && op <= 10) order.push_back(i);
        end
        n = (order.size() < freeq.size()) ? order.size() : freeq.size();
        m_num = '0;
        for (int k = 0; k < 3; k++) if (md[k]) m_busy[k] = 1'b0;
        for (int x = 0; x < n; x++) begin
            int rq = order[x];
            int al = freeq[x];
            g[rq] = 1'b1;
            m_num[al] = 1'b1;
            m_opt[4*al +: 4] = o[4*rq +: 4];
            m_tag[TW*al +: TW] = t[TW*rq +: TW];
            m_busy[al] = (o[4*rq +: 4] >= 4'd7);
        end
        if (n > 0) m_rr = (order[n-1] + 1) % N;
    endtask

    function automatic logic [23:0] tags4(int a, int b, int c, int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    vec_t tbl[14];
    vec_t hs[4];
    logic [3:0] g12, g13;

    initial begin
`ifdef ALU_SCHED_RR_EN
        g12 = 4'b1011; g13 = 4'b1101;
`else
        g12 = 4'b0111; g13 = 4'b0111;
`endif
        tbl[0]  = mk(1'b1, 4'hf, 16'h1111, tags4(10,11,12,13), 3'b000, 4'h0, 3'b000, 3'b000, 1'b1, 18'h0);
        tbl[1]  = mk(1'b0, 4'h1, 16'h0008, tags4(5,0,0,0),     3'b000, 4'h1, 3'b001, 3'b001, 1'b1, 18'd5);
        tbl[2]  = mk(1'b0, 4'he, 16'h1111, tags4(1,2,3,4),     3'b000, 4'h6, 3'b110, 3'b001, 1'b0, 18'h0);
        tbl[3]  = mk(1'b0, 4'h1, 16'h1111, tags4(1,2,3,4),     3'b001, 4'h1, 3'b001, 3'b000, 1'b0, 18'h0);
        tbl[4]  = mk(1'b0, 4'h7, 16'h0aaa, tags4(1,2,3,4),     3'b000, 4'h7, 3'b111, 3'b111, 1'b0, 18'h0);
        tbl[5]  = mk(1'b0, 4'h1, 16'h1111, tags4(1,2,3,4),     3'b000, 4'h0, 3'b000, 3'b111, 1'b0, 18'h0);
        tbl[6]  = mk(1'b0, 4'h1, 16'h1111, tags4(1,2,3,4),     3'b000, 4'h0, 3'b000, 3'b111, 1'b0, 18'h0);
        tbl[7]  = mk(1'b0, 4'h1, 16'h1111, tags4(1,2,3,4),     3'b010, 4'h1, 3'b010, 3'b101, 1'b0, 18'h0);
        tbl[8]  = mk(1'b0, 4'h3, 16'h00f0, tags4(1,2,3,4),     3'b000, 4'h0, 3'b000, 3'b101, 1'b0, 18'h0);
        tbl[9]  = mk(1'b1, 4'hf, 16'h1111, tags4(1,2,3,4),     3'b000, 4'h0, 3'b000, 3'b000, 1'b1, 18'h0);
        tbl[10] = mk(1'b0, 4'h0, 16'h1111, tags4(1,2,3,4),     3'b111, 4'h0, 3'b000, 3'b000, 1'b0, 18'h0);
        tbl[11] = mk(1'b0, 4'hf, 16'h1111, tags4(10,11,12,13), 3'b000, 4'h7, 3'b111, 3'b000, 1'b1,
                     {6'd12, 6'd11, 6'd10});
        tbl[12] = mk(1'b0, 4'hf, 16'h1111, tags4(10,11,12,13), 3'b000, g12,  3'b111, 3'b000, 1'b0, 18'h0);
        tbl[13] = mk(1'b0, 4'hf, 16'h1111, tags4(10,11,12,13), 3'b000, g13,  3'b111, 3'b000, 1'b0, 18'h0);

        // Memory op re-granted on its own release cycle keeps the ALU busy; stray mem_done is ignored.
        hs[0] = mk(1'b0, 4'h1, 16'h0008, tags4(7,0,0,0), 3'b000, 4'h1, 3'b001, 3'b001, 1'b0, 18'h0);
        hs[1] = mk(1'b0, 4'h1, 16'h0008, tags4(8,0,0,0), 3'b001, 4'h1, 3'b001, 3'b001, 1'b0, 18'h0);
        hs[2] = mk(1'b0, 4'h0, 16'h0008, tags4(8,0,0,0), 3'b001, 4'h0, 3'b000, 3'b000, 1'b0, 18'h0);
        hs[3] = mk(1'b0, 4'h0, 16'h0008, tags4(8,0,0,0), 3'b111, 4'h0, 3'b000, 3'b000, 1'b0, 18'h0);

        rst = 1'b1; req_valid = '0; req_optype = '0; req_tag = '0; mem_done = '0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("tbl%0d", i));
        for (int i = 0; i < 4; i++)  apply(hs[i], $sformatf("seq%0d", i));

        m_num = '0; m_busy = '0; m_opt = '0; m_tag = '0; m_rr = 0;
        for (int c = 0; c < 400; c++) begin
            logic        r;
            logic [3:0]  v, eg;
            logic [15:0] o;
            logic [23:0] t;
            logic [2:0]  md;
            r = (c == 0) || ($urandom_range(0, 49) == 0);
            v = 4'($urandom);
            for (int i = 0; i < N; i++)
                o[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                          : 4'($urandom_range(1, 10));
            t  = 24'($urandom);
            md = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            rst = r; req_valid = v; req_optype = o; req_tag = t; mem_done = md;
            model_step(r, v, o, t, md, eg);
            #1;
            chk("rand_grant", 32'(req_grant), 32'(eg));
            @(posedge clk); #1;
            chk("rand_number", 32'(alu_number), 32'(m_num));
            chk("rand_busy",   32'(alu_busy),   32'(m_busy));
            chk("rand_optype", 32'(alu_optype), 32'(m_opt));
            chk("rand_tag",    32'(alu_tag),    32'(m_tag));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_issue_sched.md
ALU_ISSUE_SCHED -- requirements
Module: alu_issue_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of reservation-station requesters (2..8).
REQ-002 Parameter TAG_W, default 6: destination physical-register tag width.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port req_valid  input  NUM_REQ  bit i set: requester i holds an instruction ready to issue.
REQ-006 Port req_optype  input  4*NUM_REQ  optype of requester i in bits [4i+3:4i] (1 ADD, 2 ADDI, 3 LUI, 4 ORI, 5 XOR, 6 SRAI, 7 LB, 8 LW, 9 SB, 10 SW).
REQ-007 Port req_tag  input  TAG_W*NUM_REQ  destination tag of requester i.
REQ-008 Port req_grant  output  NUM_REQ  combinational; bit i set: requester i accepted this cycle and SHALL drop its entry.
REQ-009 Port mem_done  input  3  bit k pulse: memory op on ALU k has completed; releases ALU k.
REQ-010 Port alu_number  output  3  registered one-hot-per-ALU issue strobe; bit k set: ALU k executes this cycle.
REQ-011 Port alu_optype  output  12  registered optype for ALU k in bits [4k+3:4k].
REQ-012 Port alu_tag  output  3*TAG_W  registered destination tag for ALU k.
REQ-013 Port alu_busy  output  3  registered; bit k set: ALU k held by an in-flight memory op.

Function
REQ-014 ALU k SHALL be free in a cycle when alu_busy[k]=0, or when alu_busy[k]=1 and mem_done[k]=1 (same-cycle release bypass).
REQ-015 Requester i SHALL be eligible only if req_valid[i]=1 and its optype is 1..10; optype 0 or 11..15 SHALL never be granted.
REQ-016 Each cycle the block SHALL grant min(eligible count, free ALU count) requesters, at most 3.
REQ-017 Eligible requesters SHALL be selected in priority order starting at rr_ptr and wrapping modulo NUM_REQ.
REQ-018 The j-th selected requester SHALL be assigned to the j-th free ALU in ascending ALU index.
REQ-019 Issue latency SHALL be one cycle: grant in cycle n -> alu_number[k]=1 with that optype/tag in cycle n+1, for exactly one cycle.
REQ-020 alu_number[k]=0 in any cycle following a cycle with no grant to ALU k; alu_optype/alu_tag SHALL then hold their previous value.
REQ-021 Optypes 1..6 SHALL NOT set alu_busy; ALU k is free again in cycle n+1 (fully pipelined).
REQ-022 Optypes 7..10 SHALL set alu_busy[k] from cycle n+1 and hold it until the cycle after mem_done[k]=1; with REQ-014, ALU k is grantable in the mem_done cycle.
REQ-023 mem_done[k] while alu_busy[k]=0 SHALL be ignored.
REQ-024 mem_done[k] and a new memory-op grant to ALU k in the same cycle: alu_busy[k] SHALL stay 1.
REQ-025 rr_ptr SHALL update to (index of last selected requester + 1) mod NUM_REQ; with no grant, rr_ptr holds.
REQ-026 req_grant SHALL depend only on current inputs and registered state; no combinational path from req_grant back into selection.

Reset
REQ-027 With rst=1 at a rising edge: alu_number=0, alu_optype=0, alu_tag=0, alu_busy=0, rr_ptr=0.
REQ-028 While rst=1, req_grant SHALL be all zero; in-flight memory ops are dropped and later mem_done pulses ignored.
REQ-029 First grant possible in the first cycle with rst=0.

Configuration
REQ-030 Macro ALU_SCHED_RR_EN defined: round-robin priority per REQ-017/REQ-025.
REQ-031 ALU_SCHED_RR_EN undefined: fixed priority, requester 0 highest; rr_ptr absent, selection always starts at index 0.

Verification
REQ-032 Reset, then req_valid=4'b1111 all ADD, tags 10..13 -> req_grant=4'b0111, next cycle alu_number=3'b111 tags 10,11,12; following cycle (RR) requester 3 granted first.
REQ-033 Requester 0 LW tag 5 alone -> ALU0 issue, alu_busy=3'b001; next 3 ADDs land on ALUs 1,2 only; mem_done[0]=1 -> ALU0 granted that cycle.
REQ-034 All three ALUs busy with SW, req_valid=4'b0001 ADD -> req_grant=0 until a mem_done pulse, then granted same cycle.
REQ-035 req_valid=4'b0011, optypes 0 and 15 -> req_grant=0, alu_number stays 0.
REQ-036 rst=1 asserted with alu_busy=3'b111 -> next cycle all outputs 0; mem_done=3'b111 after reset -> alu_busy stays 0.
REQ-037 ALU_SCHED_RR_EN undefined, req_valid=4'b1111 held 3 cycles -> req_grant=4'b0111 every cycle.
